ram_arbiter: RTL and testbench

Round-robin arbiter that shares one single-port `ram` instance among `N_REQ` requesters. Grants at most one access per cycle, performs writes at the clock edge and returns registered read data one cycle after the grant. Sits between the requesting datapath blocks (DMA, CPU-side loader, test port) and the RAM, so that no requester drives the RAM directly.

---
 rtl/ram_arb_pkg.sv | 22 ++
 rtl/ram.sv | 25 ++
 rtl/rr_picker.sv | 29 ++
 rtl/ram_arbiter.sv | 95 +++++++++
 tb/tb_ram_arbiter.sv | 185 ++++++++++++++++++
 5 files changed

// File: rtl/ram_arb_pkg.sv
// Shared helpers for the RAM arbiter slice.
// Address/pointer width functions and the requester-count range check.
package ram_arb_pkg;

    localparam int N_REQ_MIN = 2;
    localparam int N_REQ_MAX = 4;

    // Address width for a RAM of n words (at least 1 bit).
    function automatic int addr_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // Round-robin pointer width for n requesters (at least 1 bit).
    function automatic int ptr_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    function automatic bit n_req_ok(input int n);
        return (n >= N_REQ_MIN) && (n <= N_REQ_MAX);
    endfunction

endpackage

// File: rtl/ram.sv
// Single-port RAM: synchronous write, combinational read.
// Ports: clk, we, address, data_in, data_out.
module ram #(
    parameter int DATA_WIDTH = 8,
    parameter int N_WORDS    = 16,
    parameter int AW         = 4
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [AW-1:0]         address,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic [DATA_WIDTH-1:0] data_out
);

    logic [DATA_WIDTH-1:0] mem [N_WORDS];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[address] <= data_in;
        end
    end

    assign data_out = mem[address];

endmodule

// File: rtl/rr_picker.sv
// Combinational rotating-priority picker.
// Ports: req (requests), ptr (highest-priority index), gnt (one-hot or zero).
module rr_picker #(
    parameter int N_REQ = 2,
    parameter int PW    = 1
) (
    input  logic [N_REQ-1:0] req,
    input  logic [PW-1:0]    ptr,
    output logic [N_REQ-1:0] gnt
);

    int  idx;
    logic found;

    // Walk ptr, ptr+1, ... modulo N_REQ; first active request wins.
    always_comb begin
        gnt   = '0;
        found = 1'b0;
        idx   = 0;
        for (int i = 0; i < N_REQ; i++) begin
            idx = (int'(ptr) + i) % N_REQ;
            if (!found && req[idx]) begin
                gnt[idx] = 1'b1;
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ram_arbiter.sv
// Round-robin arbiter sharing one single-port RAM among N_REQ requesters.
// Ports: clk, rst_n, req/we/addr/wdata (per requester), gnt, rvalid, rdata.
module ram_arbiter
    import ram_arb_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int N_WORDS    = 16,
    parameter int N_REQ      = 2,
    localparam int AW        = addr_w(N_WORDS)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [N_REQ-1:0]            req,
    input  logic [N_REQ-1:0]            we,
    input  logic [N_REQ*AW-1:0]         addr,
    input  logic [N_REQ*DATA_WIDTH-1:0] wdata,
    output logic [N_REQ-1:0]            gnt,
    output logic [N_REQ-1:0]            rvalid,
    output logic [DATA_WIDTH-1:0]       rdata
);

    localparam int PW = ptr_w(N_REQ);

    generate
        if (!n_req_ok(N_REQ)) begin : g_bad_n_req
            $error("ram_arbiter: N_REQ must be in 2..4");
        end
    endgenerate

    logic [PW-1:0]         ptr;
    logic [PW-1:0]         ptr_nxt;
    logic [N_REQ-1:0]      pick;
    logic [N_REQ-1:0]      rd_gnt;
    logic                  ram_we;
    logic [AW-1:0]         ram_addr;
    logic [DATA_WIDTH-1:0] ram_din;
    logic [DATA_WIDTH-1:0] ram_dout;

    rr_picker #(
        .N_REQ (N_REQ),
        .PW    (PW)
    ) u_picker (
        .req (req),
        .ptr (ptr),
        .gnt (pick)
    );

    // Grant is suppressed in reset so no RAM write can slip through.
    assign gnt = rst_n ? pick : '0;

    // gnt is one-hot or zero, so the mux idles at address 0, we 0.
    always_comb begin
        ram_we   = 1'b0;
        ram_addr = '0;
        ram_din  = '0;
        rd_gnt   = '0;
        ptr_nxt  = ptr;
        for (int i = 0; i < N_REQ; i++) begin
            if (gnt[i]) begin
                ram_we    = we[i];
                ram_addr  = addr[i*AW +: AW];
                ram_din   = wdata[i*DATA_WIDTH +: DATA_WIDTH];
                rd_gnt[i] = ~we[i];
                ptr_nxt   = PW'((i + 1) % N_REQ);
            end
        end
    end

    ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .N_WORDS    (N_WORDS),
        .AW         (AW)
    ) u_ram (
        .clk      (clk),
        .we       (ram_we),
        .address  (ram_addr),
        .data_in  (ram_din),
        .data_out (ram_dout)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr    <= '0;
            rvalid <= '0;
            rdata  <= '0;
        end else begin
            ptr    <= ptr_nxt;
            rvalid <= rd_gnt;
            if (|rd_gnt) begin
                rdata <= ram_dout;
            end
        end
    end

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed, table-driven bench for ram_arbiter (N_REQ=2, 8x16 RAM).
// Vectors plus hand sequences for reset-mid-read and idle behaviour.
module tb_ram_arbiter;

    localparam int DW = 8;
    localparam int NW = 16;
    localparam int NR = 2;
    localparam int AW = 4;

    logic          clk;
    logic          rst_n;
    logic [NR-1:0] req;
    logic [NR-1:0] we;
    logic [NR*AW-1:0] addr;
    logic [NR*DW-1:0] wdata;
    logic [NR-1:0] gnt;
    logic [NR-1:0] rvalid;
    logic [DW-1:0] rdata;

    int n_cmp;
    int n_bad;

    ram_arbiter #(
        .DATA_WIDTH (DW),
        .N_WORDS    (NW),
        .N_REQ      (NR)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .req    (req),
        .we     (we),
        .addr   (addr),
        .wdata  (wdata),
        .gnt    (gnt),
        .rvalid (rvalid),
        .rdata  (rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (req[0]) assert (int'(addr[0*AW +: AW]) < NW);
        if (req[1]) assert (int'(addr[1*AW +: AW]) < NW);
    end

    typedef struct {
        logic          rst_n;
        logic [1:0]    req;
        logic [1:0]    we;
        logic [3:0]    a0;
        logic [3:0]    a1;
        logic [7:0]    wd0;
        logic [7:0]    wd1;
        logic [1:0]    e_gnt;
        logic [1:0]    e_rv;
        logic [7:0]    e_rd;
    } vec_t;

    vec_t v [17];

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic [1:0] rq,
                         input logic [1:0] w, input logic [3:0] a0,
                         input logic [3:0] a1, input logic [7:0] d0,
                         input logic [7:0] d1);
        rst_n = r;
        req   = rq;
        we    = w;
        addr  = {a1, a0};
        wdata = {d1, d0};
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        //        rst req   we    a0 a1 wd0    wd1    gnt   rv    rd
        v[0]  = '{1, 2'b01, 2'b01, 3, 0, 8'hA5, 8'h00, 2'b01, 2'b00, 8'h00};
        v[1]  = '{1, 2'b01, 2'b00, 3, 0, 8'h00, 8'h00, 2'b01, 2'b00, 8'h00};
        v[2]  = '{1, 2'b00, 2'b00, 0, 0, 8'h00, 8'h00, 2'b00, 2'b01, 8'hA5};
        v[3]  = '{1, 2'b10, 2'b10, 0, 1, 8'h00, 8'h11, 2'b10, 2'b00, 8'hA5};
        v[4]  = '{1, 2'b01, 2'b01, 2, 0, 8'h22, 8'h00, 2'b01, 2'b00, 8'hA5};
        v[5]  = '{0, 2'b11, 2'b00, 1, 2, 8'h00, 8'h00, 2'b00, 2'b00, 8'hA5};
        v[6]  = '{1, 2'b11, 2'b00, 1, 2, 8'h00, 8'h00, 2'b01, 2'b00, 8'h00};
        v[7]  = '{1, 2'b11, 2'b00, 1, 2, 8'h00, 8'h00, 2'b10, 2'b01, 8'h11};
        v[8]  = '{1, 2'b11, 2'b00, 1, 2, 8'h00, 8'h00, 2'b01, 2'b10, 8'h22};
        v[9]  = '{1, 2'b11, 2'b00, 1, 2, 8'h00, 8'h00, 2'b10, 2'b01, 8'h11};
        v[10] = '{1, 2'b10, 2'b00, 0, 1, 8'h00, 8'h00, 2'b10, 2'b10, 8'h22};
        v[11] = '{1, 2'b11, 2'b00, 2, 1, 8'h00, 8'h00, 2'b01, 2'b10, 8'h11};
        v[12] = '{1, 2'b11, 2'b00, 2, 1, 8'h00, 8'h00, 2'b10, 2'b01, 8'h22};
        v[13] = '{1, 2'b01, 2'b01, 15, 0, 8'h3C, 8'h00, 2'b01, 2'b10, 8'h11};
        v[14] = '{1, 2'b10, 2'b00, 0, 15, 8'h00, 8'h00, 2'b10, 2'b00, 8'h11};
        v[15] = '{1, 2'b00, 2'b00, 0, 0, 8'h00, 8'h00, 2'b00, 2'b10, 8'h3C};
        v[16] = '{1, 2'b00, 2'b00, 0, 0, 8'h00, 8'h00, 2'b00, 2'b00, 8'h3C};

        // Reset with requests pending: no grant, outputs cleared.
        drive(0, 2'b11, 2'b11, 5, 6, 8'hEE, 8'hEE);
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        check("rst_gnt", 32'(gnt), 32'h0);
        check("rst_rvalid", 32'(rvalid), 32'h0);
        check("rst_rdata", 32'(rdata), 32'h0);

        for (int i = 0; i < 17; i++) begin
            @(negedge clk);
            drive(v[i].rst_n, v[i].req, v[i].we, v[i].a0, v[i].a1,
                  v[i].wd0, v[i].wd1);
            #1;
            check($sformatf("v%0d_gnt", i), 32'(gnt), 32'(v[i].e_gnt));
            check($sformatf("v%0d_rvalid", i), 32'(rvalid), 32'(v[i].e_rv));
            check($sformatf("v%0d_rdata", i), 32'(rdata), 32'(v[i].e_rd));
        end

        // Reset mid-read: in-flight rvalid dropped, writes blocked.
        @(negedge clk);
        drive(1, 2'b01, 2'b00, 3, 0, 8'h00, 8'h00);
        #1;
        check("mr_gnt", 32'(gnt), 32'h1);
        @(negedge clk);
        drive(0, 2'b11, 2'b11, 3, 15, 8'hFF, 8'hFF);
        #1;
        check("mr_rst_gnt", 32'(gnt), 32'h0);
        check("mr_pre_rv", 32'(rvalid), 32'h1);
        check("mr_pre_rd", 32'(rdata), 32'hA5);
        @(negedge clk);
        #1;
        check("mr_rst_gnt2", 32'(gnt), 32'h0);
        check("mr_rst_rv", 32'(rvalid), 32'h0);
        check("mr_rst_rd", 32'(rdata), 32'h0);
        @(negedge clk);
        drive(1, 2'b01, 2'b00, 3, 0, 8'h00, 8'h00);
        #1;
        check("mr_rel_gnt", 32'(gnt), 32'h1);
        @(negedge clk);
        drive(1, 2'b10, 2'b00, 0, 15, 8'h00, 8'h00);
        #1;
        check("mr_rd3_gnt", 32'(gnt), 32'h2);
        check("mr_rd3_rv", 32'(rvalid), 32'h1);
        check("mr_rd3_rd", 32'(rdata), 32'hA5);

        // Idle with we/wdata toggled: nothing changes.
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            drive(1, 2'b00, 2'b11, 3, 15, 8'h5A, 8'h5A);
            #1;
            check($sformatf("idle%0d_gnt", i), 32'(gnt), 32'h0);
            if (i == 0)
                check("idle0_rv", 32'(rvalid), 32'h2);
            else
                check($sformatf("idle%0d_rv", i), 32'(rvalid), 32'h0);
            check($sformatf("idle%0d_rd", i), 32'(rdata), 32'h3C);
        end

        // Pointer held at 0 across idle; RAM unchanged.
        @(negedge clk);
        drive(1, 2'b11, 2'b00, 3, 15, 8'h00, 8'h00);
        #1;
        check("post_gnt0", 32'(gnt), 32'h1);
        check("post_rv0", 32'(rvalid), 32'h0);
        @(negedge clk);
        drive(1, 2'b10, 2'b00, 3, 15, 8'h00, 8'h00);
        #1;
        check("post_gnt1", 32'(gnt), 32'h2);
        check("post_rv1", 32'(rvalid), 32'h1);
        check("post_rd1", 32'(rdata), 32'hA5);
        @(negedge clk);
        drive(1, 2'b00, 2'b00, 0, 0, 8'h00, 8'h00);
        #1;
        check("post_rv2", 32'(rvalid), 32'h2);
        check("post_rd2", 32'(rdata), 32'h3C);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
